// File: rtl/sbox6_inverse_search.sv
// ---------------------------------------------------------------------------
// sbox6_inverse_search
//
// Sequential inverse lookup for DES S-box 6. Given a 2-bit row and a 4-bit
// S-box output value, it scans the 16 columns of that row, one per clock,
// through a single sbox6 instance. It reports the 6-bit S-box input that
// produces the value.
//
// Parameters:
//   EARLY_EXIT   1 = stop at the first matching column,
//                0 = always scan all 16 columns (constant 16-cycle latency)
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_valid     request valid
//   in_ready     request can be accepted (high only in IDLE)
//   in_row       target row {sbox_in[5], sbox_in[0]}
//   in_value     target S-box output value
//   out_valid    result valid, held until out_ready
//   out_ready    consumer accepts the result
//   out_sbox_in  recovered input {row[1], col[3:0], row[0]}, 0 if not found
//   out_found    a matching column was found
//   busy         high in SEARCH or DONE
// ---------------------------------------------------------------------------

// sbox6: combinational DES S-box 6 (6-bit input, 4-bit output).
// Ports: sbox_in = {row[1], col[3:0], row[0]}, sbox_out = table entry.
module sbox6 (
    input  logic [5:0] sbox_in,
    output logic [3:0] sbox_out
);
    // Each row is packed with column 0 in the most significant nibble.
    localparam logic [63:0] ROW0 = 64'hC1AF_9268_0D34_E75B;
    localparam logic [63:0] ROW1 = 64'hAF42_7C95_61DE_0B38;
    localparam logic [63:0] ROW2 = 64'h9EF5_28C3_704A_1DB6;
    localparam logic [63:0] ROW3 = 64'h432C_95FA_BE17_608D;

    logic [1:0]  row_s;
    logic [3:0]  col_s;
    logic [63:0] row_bits_s;
    logic [5:0]  lsb_s;

    assign row_s = {sbox_in[5], sbox_in[0]};
    assign col_s = sbox_in[4:1];
    // Bit offset of the selected nibble: column 0 sits at bits [63:60].
    assign lsb_s = 6'd60 - {col_s, 2'b00};

    // Row selection and nibble extraction
    always_comb begin
        row_bits_s = 64'd0;
        case (row_s)
            2'd0:    row_bits_s = ROW0;
            2'd1:    row_bits_s = ROW1;
            2'd2:    row_bits_s = ROW2;
            2'd3:    row_bits_s = ROW3;
            default: row_bits_s = 64'd0;
        endcase
        sbox_out = row_bits_s[lsb_s +: 4];
    end
endmodule

module sbox6_inverse_search #(
    parameter int unsigned EARLY_EXIT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] in_row,
    input  logic [3:0] in_value,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [5:0] out_sbox_in,
    output logic       out_found,
    output logic       busy
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t      state_r;
    logic [3:0]  col_r;
    logic [1:0]  row_r;
    logic [3:0]  value_r;
    logic        in_ready_r;
    logic        out_valid_r;
    logic [5:0]  out_sbox_in_r;
    logic        out_found_r;
    logic        busy_r;

    logic [5:0]  cand_s;
    logic [3:0]  sbox_out_s;
    logic        match_s;
    logic        last_col_s;

    // Candidate input for the column under test this cycle.
    assign cand_s     = {row_r[1], col_r, row_r[0]};
    assign match_s    = (sbox_out_s == value_r);
    assign last_col_s = (col_r == 4'd15);

    sbox6 u_sbox6 (
        .sbox_in  (cand_s),
        .sbox_out (sbox_out_s)
    );

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign out_sbox_in = out_sbox_in_r;
    assign out_found   = out_found_r;
    assign busy        = busy_r;

    // Search controller: request capture, column scan and result handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            col_r         <= 4'd0;
            row_r         <= 2'd0;
            value_r       <= 4'd0;
            in_ready_r    <= 1'b1;
            out_valid_r   <= 1'b0;
            out_sbox_in_r <= 6'd0;
            out_found_r   <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        row_r         <= in_row;
                        value_r       <= in_value;
                        col_r         <= 4'd0;
                        out_sbox_in_r <= 6'd0;
                        out_found_r   <= 1'b0;
                        in_ready_r    <= 1'b0;
                        busy_r        <= 1'b1;
                        state_r       <= ST_SEARCH;
                    end else begin
                        in_ready_r    <= 1'b1;
                    end
                end

                ST_SEARCH: begin
                    if (EARLY_EXIT != 0) begin
                        if (match_s) begin
                            out_sbox_in_r <= cand_s;
                            out_found_r   <= 1'b1;
                            out_valid_r   <= 1'b1;
                            state_r       <= ST_DONE;
                        end else if (last_col_s) begin
                            out_sbox_in_r <= 6'd0;
                            out_found_r   <= 1'b0;
                            out_valid_r   <= 1'b1;
                            state_r       <= ST_DONE;
                        end else begin
                            col_r         <= col_r + 4'd1;
                        end
                    end else begin
                        // Keep the first match; later matches cannot occur
                        // in a permutation row but are ignored regardless.
                        if (match_s && !out_found_r) begin
                            out_sbox_in_r <= cand_s;
                            out_found_r   <= 1'b1;
                        end
                        if (last_col_s) begin
                            out_valid_r   <= 1'b1;
                            state_r       <= ST_DONE;
                        end else begin
                            col_r         <= col_r + 4'd1;
                        end
                    end
                end

                ST_DONE: begin
                    // in_ready rises only after the result is consumed, so a
                    // new request can never be taken in the consuming cycle.
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= ST_IDLE;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end

                default: begin
                    state_r       <= ST_IDLE;
                    col_r         <= 4'd0;
                    in_ready_r    <= 1'b1;
                    out_valid_r   <= 1'b0;
                    out_sbox_in_r <= 6'd0;
                    out_found_r   <= 1'b0;
                    busy_r        <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sbox6_inverse_search.sv
// ---------------------------------------------------------------------------
// tb_sbox6_inverse_search
//
// Drives the same request stream into two instances (EARLY_EXIT=1 and
// EARLY_EXIT=0). Each request's expected result is derived from the DES
// S-box 6 table and pushed into a per-instance queue. A negedge monitor pops
// and compares whenever an instance presents a new result.
// ---------------------------------------------------------------------------
module tb_sbox6_inverse_search;
    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [1:0] in_row;
    logic [3:0] in_value;
    logic       out_ready;

    logic [1:0] ir;
    logic [1:0] ov;
    logic [1:0] of;
    logic [1:0] bsy;
    logic [5:0] osb [2];

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    bit bp_hold = 1'b0;

    // DES S-box 6, rows 0..3, columns 0..15
    int s6 [4][16] = '{
        '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11},
        '{10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8},
        '{ 9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6},
        '{ 4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13}
    };

    typedef struct {
        int row;
        int value;
        int exp_in;
        int exp_found;
        int exp_lat;
        int acc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    bit seen [2];
    int hold_sb [2];
    int hold_f [2];

    sbox6_inverse_search #(.EARLY_EXIT(1)) u_dut_ee (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(ir[0]),
        .in_row(in_row), .in_value(in_value),
        .out_valid(ov[0]), .out_ready(out_ready),
        .out_sbox_in(osb[0]), .out_found(of[0]), .busy(bsy[0])
    );

    sbox6_inverse_search #(.EARLY_EXIT(0)) u_dut_full (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(ir[1]),
        .in_row(in_row), .in_value(in_value),
        .out_valid(ov[1]), .out_ready(out_ready),
        .out_sbox_in(osb[1]), .out_found(of[1]), .busy(bsy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int find_col(input int r, input int v);
        for (int c = 0; c < 16; c++)
            if (s6[r][c] == v) return c;
        return -1;
    endfunction

    function automatic int sbox_ref(input logic [5:0] x);
        int r;
        int c;
        r = {30'd0, x[5], x[0]};
        c = {28'd0, x[4:1]};
        return s6[r][c];
    endfunction

    // Random consumer backpressure, forced low while bp_hold is set
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            out_ready = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: compare each new result, then check it stays stable
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                seen[d] = 1'b0;
            end else if (ov[d]) begin
                if (!seen[d]) begin
                    exp_t e;
                    bit have;
                    have = 1'b0;
                    if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
                    if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
                    if (!have) begin
                        chk($sformatf("unexpected_result_dut%0d", d), 1, 0);
                    end else begin
                        chk($sformatf("sbox_in_dut%0d r%0d v%0d", d, e.row, e.value),
                            int'(osb[d]), e.exp_in);
                        chk($sformatf("found_dut%0d r%0d v%0d", d, e.row, e.value),
                            int'(of[d]), e.exp_found);
                        chk($sformatf("latency_dut%0d r%0d v%0d", d, e.row, e.value),
                            cyc - e.acc, e.exp_lat);
                        chk($sformatf("ref_roundtrip_dut%0d r%0d v%0d", d, e.row, e.value),
                            sbox_ref(osb[d]), e.value);
                    end
                    hold_sb[d] = int'(osb[d]);
                    hold_f[d]  = int'(of[d]);
                    seen[d]    = 1'b1;
                end else begin
                    chk($sformatf("hold_sbox_in_dut%0d", d), int'(osb[d]), hold_sb[d]);
                    chk($sformatf("hold_found_dut%0d", d), int'(of[d]), hold_f[d]);
                    chk($sformatf("in_ready_in_done_dut%0d", d), int'(ir[d]), 0);
                    chk($sformatf("busy_in_done_dut%0d", d), int'(bsy[d]), 1);
                end
                // Consumed at the next rising edge
                if (out_ready) seen[d] = 1'b0;
            end else if (seen[d]) begin
                chk($sformatf("out_valid_dropped_dut%0d", d), 0, 1);
                seen[d] = 1'b0;
            end
        end
    end

    task automatic chk_reset(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_in_ready_dut%0d", tag, d), int'(ir[d]), 1);
            chk($sformatf("%s_out_valid_dut%0d", tag, d), int'(ov[d]), 0);
            chk($sformatf("%s_out_sbox_in_dut%0d", tag, d), int'(osb[d]), 0);
            chk($sformatf("%s_out_found_dut%0d", tag, d), int'(of[d]), 0);
            chk($sformatf("%s_busy_dut%0d", tag, d), int'(bsy[d]), 0);
        end
    endtask

    // Called at posedge+1; issues one request once both instances are idle
    task automatic send(input int r, input int v);
        int n;
        int c;
        exp_t e;
        n = 0;
        while (!(ir[0] && ir[1]) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 300) begin
            chk("send_wait_timeout", 0, 1);
            return;
        end
        in_row   = r[1:0];
        in_value = v[3:0];
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        c = find_col(r, v);
        e.row       = r;
        e.value     = v;
        e.exp_found = (c >= 0) ? 1 : 0;
        e.exp_in    = (c >= 0) ? ((r / 2) * 32 + c * 2 + (r % 2)) : 0;
        e.acc       = cyc;
        e.exp_lat   = (c >= 0) ? (c + 1) : 16;
        q0.push_back(e);
        e.exp_lat   = 16;
        q1.push_back(e);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(ir[0] && ir[1] && q0.size() == 0 && q1.size() == 0) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 500) chk("drain_timeout", 0, 1);
    endtask

    initial begin
        int n;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_row   = 2'd0;
        in_value = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed requests from the known table corners
        send(0, 12);
        send(0, 11);
        send(1, 15);
        send(2, 7);
        send(3, 13);

        // Every row/value pair
        for (int r = 0; r < 4; r++)
            for (int v = 0; v < 16; v++)
                send(r, v);

        // Random requests
        for (int i = 0; i < 30; i++)
            send($urandom_range(0, 3), $urandom_range(0, 15));
        wait_idle();

        // Backpressure: results held with stray requests on the input
        bp_hold   = 1'b1;
        out_ready = 1'b0;
        send(2, 7);
        n = 0;
        while (ov != 2'b11 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) chk("bp_wait_timeout", 0, 1);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            in_row   = 2'($urandom_range(0, 3));
            in_value = 4'($urandom_range(0, 15));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("bp_out_valid_held", int'(ov), 3);
        bp_hold = 1'b0;
        wait_idle();
        send(1, 15);
        wait_idle();

        // Reset during the fifth search cycle aborts without a result
        send(0, 11);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("midreset");
        q0.delete();
        q1.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(3, 4);
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/sbox6_inverse_search.md
Name: sbox6_inverse_search

Overview:
Sequential inverse lookup for DES S-box 6, the decode direction of the existing SBox6 block. It takes a 4-bit S-box output value and the 2-bit row, then finds the 6-bit S-box input that produces that value. It searches by driving one SBox6 instance with one candidate column per clock. It sits beside the S-box path and serves key-recovery and diagnostic logic through a valid/ready request and response interface.

Parameters:
EARLY_EXIT, 1, 1 = stop the search at the first match; 0 = always scan all 16 columns so latency is constant.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
rst_n  input  1  reset, asynchronous, active-low.
in_valid  input  1  request valid.
in_ready  output  1  block can accept a request; high only in IDLE.
in_row  input  2  target row: {sbox_in[5], sbox_in[0]}.
in_value  input  4  target S-box output value.
out_valid  output  1  result valid; held until accepted.
out_ready  input  1  consumer accepts the result.
out_sbox_in  output  6  recovered S-box input {row[1], col[3:0], row[0]}; 0 when not found.
out_found  output  1  a match was found.
busy  output  1  high in SEARCH or DONE.

Behaviour:
- Reset (asynchronous, while rst_n=0):
  - state=IDLE, in_ready=1, out_valid=0, out_sbox_in=0, out_found=0, busy=0.
  - Column counter and latched row/value cleared.
  - Reset asserted mid-search or while in DONE aborts the operation immediately; no result is issued.
- States: IDLE, SEARCH, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at a rising edge: latch in_row and in_value, col<=0, go to SEARCH.
- SEARCH:
  - Each cycle, one internal SBox6 instance is driven combinationally with {row[1], col, row[0]}, and its output is compared to the latched value.
  - EARLY_EXIT=1:
    - On match: capture out_sbox_in={row[1], col, row[0]}, out_found<=1, go to DONE.
    - Else if col==15: out_found<=0, out_sbox_in<=0, go to DONE.
    - Else: col<=col+1.
  - EARLY_EXIT=0:
    - On match: capture the result but keep scanning (first match is retained).
    - Go to DONE after col==15 is evaluated.
    - out_found reflects whether any match occurred.
  - The counter is 4 bits and never wraps. Leaving SEARCH at col==15 is mandatory.
- DONE:
  - out_valid=1; out_sbox_in and out_found are stable.
  - On out_ready: go to IDLE. in_ready rises the following cycle.
  - A new request cannot be accepted in the same cycle the result is consumed.
- Latency, measured from the accepting edge to the first cycle out_valid is high:
  - EARLY_EXIT=1, match at column c: c+1 cycles (1 to 16).
  - EARLY_EXIT=0: always 16 cycles.
- in_valid, in_row and in_value are ignored outside IDLE.
- out_ready is ignored when out_valid=0.
- out_valid never deasserts without out_ready, except under reset.
- Each S-box row is a permutation of 0..15, so out_found=1 for every legal request. The not-found path exists only to guarantee defined outputs.

Test Plan:
- Reset then row=00, value=12, EARLY_EXIT=1 -> out_sbox_in=6'h00, found=1, out_valid 1 cycle after accept.
- row=00, value=11 -> out_sbox_in=6'h1E, found=1, latency 16; repeat with EARLY_EXIT=0 -> same result, latency 16.
- row=01, value=15 -> 6'h03 (latency 2); row=10, value=7 -> 6'h30 (latency 9); row=11, value=13 -> 6'h3F; with EARLY_EXIT=0 each has latency 16.
- Exhaustive: all 64 row/value pairs, each result fed through a reference SBox6 -> reproduces the requested value; out_found=1 every time.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid and data stable, in_ready=0, extra in_valid pulses ignored; release -> IDLE, next request served correctly.
- Pull rst_n low at the 5th search cycle -> outputs return to reset values immediately; after release, a new request row=11, value=4 -> 6'h21.
